// File: rtl/iob_mem_responder_pkg.sv
// Shared types and constants for the IOb memory responder.
package iob_mem_responder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] OOR_RDATA = 32'hDEADBEEF;
  localparam int          WCNT_W    = 4;

endpackage

// File: rtl/iob_ram_sp_be.sv
// Synchronous single-port word RAM with per-byte write enables and a 1-cycle read.
// Read data only changes on a read access, so it holds between read responses.
module iob_ram_sp_be #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_W/8-1:0]   we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i && (we_i == '0)) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_mem_responder.sv
// IOb native-bus responder fronting a byte-enable word RAM, with optional wait states.
// Define IOB_MEM_RESPONDER_RANGE_CHK_EN to enable out-of-range detection and err_o.
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cke_i,
  input  logic                  iob_avalid_i,
  input  logic [ADDR_W-1:0]     iob_addr_i,
  input  logic [DATA_W-1:0]     iob_wdata_i,
  input  logic [DATA_W/8-1:0]   iob_wstrb_i,
  output logic                  iob_ready_o,
  output logic                  iob_rvalid_o,
  output logic [DATA_W-1:0]     iob_rdata_o,
  output logic                  err_o
);

  localparam int STRB_W  = DATA_W/8;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  state_e              state_q;
  logic [WCNT_W-1:0]   cnt_q;
  logic                ready_q;
  logic                rvalid_q;
  logic                oor_rd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic                accept;
  logic                commit;
  logic                acc_rd;
  logic                acc_oor;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [STRB_W-1:0]   acc_wstrb;
  logic [DATA_W-1:0]   ram_rdata;

  assign accept = cke_i & iob_avalid_i & ready_q;

  // Without wait states the access uses the live request; otherwise the captured copy.
  assign acc_addr  = (state_q == ST_WAIT) ? addr_q  : iob_addr_i;
  assign acc_wdata = (state_q == ST_WAIT) ? wdata_q : iob_wdata_i;
  assign acc_wstrb = (state_q == ST_WAIT) ? wstrb_q : iob_wstrb_i;
  assign acc_rd    = (acc_wstrb == '0);

  assign commit = NO_WAIT ? accept
                          : (cke_i && (state_q == ST_WAIT) && (cnt_q == WCNT_W'(1)));

`ifdef IOB_MEM_RESPONDER_RANGE_CHK_EN
  logic err_q;
  logic unused_addr;

  assign acc_oor     = |acc_addr[ADDR_W-1:MEM_ADDR_W+2];
  assign unused_addr = ^acc_addr[1:0];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_q <= 1'b0;
    end else if (commit && acc_oor) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_addr;

  assign acc_oor     = 1'b0;
  assign unused_addr = ^{acc_addr[ADDR_W-1:MEM_ADDR_W+2], acc_addr[1:0]};
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= iob_addr_i;
      wdata_q <= iob_wdata_i;
      wstrb_q <= iob_wstrb_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      oor_rd_q <= 1'b0;
    end else if (cke_i) begin
      rvalid_q <= commit && acc_rd;
      if (commit && acc_rd) oor_rd_q <= acc_oor;
      case (state_q)
        ST_IDLE: begin
          if (accept && !NO_WAIT) begin
            cnt_q   <= WCNT_W'(WAIT_CYCLES);
            state_q <= ST_WAIT;
            ready_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - WCNT_W'(1);
          if (cnt_q == WCNT_W'(1)) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  iob_ram_sp_be #(
    .ADDR_W (MEM_ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (arst_i),
    .en_i    (commit & ~acc_oor),
    .we_i    (acc_wstrb),
    .addr_i  (acc_addr[MEM_ADDR_W+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  assign iob_ready_o  = ready_q;
  assign iob_rvalid_o = rvalid_q;
  assign iob_rdata_o  = oor_rd_q ? OOR_RDATA : ram_rdata;

endmodule

// File: tb/tb_iob_mem_responder.sv
// Scoreboard bench for iob_mem_responder: one instance without and one with 3 wait states.
module tb_iob_mem_responder;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        arst0, cke0, av0, rdy0, rv0, err0;
  logic [31:0] addr0, wd0, rd0;
  logic [3:0]  ws0;
  logic        arst3, cke3, av3, rdy3, rv3, err3;
  logic [31:0] addr3, wd3, rd3;
  logic [3:0]  ws3;

  logic [31:0] mem0 [int];
  logic [31:0] mem3 [int];
  exp_t        q0[$];
  exp_t        q3[$];
  logic [31:0] last0 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .arst_i(arst0), .cke_i(cke0), .iob_avalid_i(av0),
    .iob_addr_i(addr0), .iob_wdata_i(wd0), .iob_wstrb_i(ws0),
    .iob_ready_o(rdy0), .iob_rvalid_o(rv0), .iob_rdata_o(rd0), .err_o(err0)
  );

  iob_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .arst_i(arst3), .cke_i(cke3), .iob_avalid_i(av3),
    .iob_addr_i(addr3), .iob_wdata_i(wd3), .iob_wstrb_i(ws3),
    .iob_ready_o(rdy3), .iob_rvalid_o(rv3), .iob_rdata_o(rd3), .err_o(err3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
`ifdef IOB_MEM_RESPONDER_RANGE_CHK_EN
    return (a[31:12] != 20'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mdl_rd(input int d, input logic [31:0] a);
    int idx;
    idx = int'(a[11:2]);
    if (is_oor(a)) return 32'hDEADBEEF;
    if (d == 0) return mem0.exists(idx) ? mem0[idx] : 32'h0;
    return mem3.exists(idx) ? mem3[idx] : 32'h0;
  endfunction

  function automatic void mdl_wr(input int d, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] w;
    int idx;
    if (is_oor(a)) return;
    idx = int'(a[11:2]);
    w = mdl_rd(d, a);
    for (int b = 0; b < 4; b++) if (ws[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    if (d == 0) mem0[idx] = w; else mem3[idx] = w;
  endfunction

  // Scoreboard monitors: every rvalid must match the oldest expected read, in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rv0) begin
      if (q0.size() == 0) chk("rv0_unexpected", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("rd0_data", rd0, e.data);
        chk("rd0_cycle", cyc, e.cyc);
        last0 = e.data;
      end
    end
    if (rv3) begin
      if (q3.size() == 0) chk("rv3_unexpected", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        chk("rd3_data", rd3, e.data);
        chk("rd3_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic req0(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    @(negedge clk);
    chk("rdy0_high", rdy0, 1'b1);
    av0 = 1'b1; addr0 = a; wd0 = wd; ws0 = ws;
    if (ws == 4'h0) begin
      e.data = mdl_rd(0, a);
      e.cyc  = cyc + 1;
      q0.push_back(e);
    end else begin
      mdl_wr(0, a, wd, ws);
    end
    @(posedge clk);
  endtask

  task automatic idle0(input int n);
    @(negedge clk);
    av0 = 1'b0; ws0 = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  // Request held through the wait states; cke3 dropped for 'stall' cycles during WAIT.
  task automatic req3(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input int stall);
    exp_t e;
    int   g;
    @(negedge clk);
    g = 0;
    while (rdy3 !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("rdy3_idle", rdy3, 1'b1);
    av3 = 1'b1; addr3 = a; wd3 = wd; ws3 = ws;
    if (ws == 4'h0) begin
      e.data = mdl_rd(3, a);
      e.cyc  = cyc + 1 + 3 + stall;
      q3.push_back(e);
    end else begin
      mdl_wr(3, a, wd, ws);
    end
    @(posedge clk);
    for (int k = 1; k <= 3 + stall; k++) begin
      @(negedge clk);
      chk("rdy3_wait", rdy3, 1'b0);
      if (k == 1 && stall > 0) cke3 = 1'b0;
      if (k == 1 + stall) cke3 = 1'b1;
    end
    @(negedge clk);
    chk("rdy3_back", rdy3, 1'b1);
    av3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arst0 = 1'b1; cke0 = 1'b1; av0 = 1'b0; addr0 = '0; wd0 = '0; ws0 = '0;
    arst3 = 1'b1; cke3 = 1'b1; av3 = 1'b0; addr3 = '0; wd3 = '0; ws3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy0", rdy0, 1'b1);
    chk("rst_rv0", rv0, 1'b0);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_err0", err0, 1'b0);
    chk("rst_rdy3", rdy3, 1'b1);
    chk("rst_rv3", rv3, 1'b0);
    chk("rst_rd3", rd3, 32'h0);
    arst0 = 1'b0; arst3 = 1'b0;

    // No wait states: full write, read-after-write, partial write, back-to-back
    req0(32'h10, 32'h11223344, 4'hF);
    req0(32'h10, 32'h0, 4'h0);
    req0(32'h10, 32'h0000AA00, 4'h2);
    req0(32'h10, 32'h0, 4'h0);
    req0(32'h14, 32'hA5A5_0F0F, 4'hF);
    req0(32'h17, 32'h0, 4'h0);
    req0(32'h10, 32'h0, 4'h0);
    req0(32'h10, 32'hFF00_0000, 4'h8);
    req0(32'h10, 32'h0, 4'h0);
    idle0(3);
    chk("rd0_hold", rd0, last0);
    req0(32'h14, 32'h1234_5678, 4'h5);
    idle0(2);
    chk("rd0_hold_after_wr", rd0, last0);
    req0(32'h14, 32'h0, 4'h0);
    idle0(2);

    // Upper address bits: range error or aliasing depending on build
    req0(32'h0, 32'h0A0B0C0D, 4'hF);
    req0(32'h1000, 32'h0, 4'h0);
    idle0(1);
`ifdef IOB_MEM_RESPONDER_RANGE_CHK_EN
    chk("err0_set", err0, 1'b1);
`else
    chk("err0_tied", err0, 1'b0);
`endif
    req0(32'h1000, 32'hFFFF_FFFF, 4'hF);
    req0(32'h0, 32'h0, 4'h0);
    idle0(3);
`ifdef IOB_MEM_RESPONDER_RANGE_CHK_EN
    chk("err0_sticky", err0, 1'b1);
`else
    chk("err0_tied2", err0, 1'b0);
`endif
    arst0 = 1'b1;
    @(negedge clk);
    chk("err0_rst", err0, 1'b0);
    arst0 = 1'b0;

    // Three wait states: handshake, held request, cke stall
    req3(32'h20, 32'h55667788, 4'hF, 0);
    req3(32'h20, 32'h0, 4'h0, 0);
    req3(32'h24, 32'h0BAD_CAFE, 4'hF, 0);
    req3(32'h24, 32'h0, 4'h0, 2);
    req3(32'h20, 32'h0, 4'h0, 0);

    // Reset during WAIT drops the pending write
    @(negedge clk);
    av3 = 1'b1; addr3 = 32'h20; wd3 = 32'hCAFE_F00D; ws3 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    av3 = 1'b0; ws3 = 4'h0;
    chk("rdy3_pre_rst", rdy3, 1'b0);
    arst3 = 1'b1;
    @(negedge clk);
    chk("rdy3_in_rst", rdy3, 1'b1);
    chk("rv3_in_rst", rv3, 1'b0);
    arst3 = 1'b0;
    repeat (4) @(negedge clk);
    chk("rv3_after_rst", rv3, 1'b0);
    req3(32'h20, 32'h0, 4'h0, 0);

    repeat (8) @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_mem_responder.md
Name: iob_mem_responder

Overview:
- IOb native-bus responder (subordinate) fronting an internal byte-enable single-port word memory.
- Other end of the CPU-side IOb initiator: takes avalid/addr/wdata/wstrb requests, returns ready, rvalid and rdata.
- Serves as boot/scratch RAM or test target on the instruction or data bus.
- Configurable wait states model slower memories.

Parameters:
- ADDR_W, 32, request byte-address width.
- DATA_W, 32, data width; only 32 is supported.
- MEM_ADDR_W, 10, word-address width; memory holds 2^MEM_ADDR_W words.
- WAIT_CYCLES, 0, extra cycles between acceptance and memory access (0..15).

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous reset, active-high
- cke_i  in  1  clock enable; low freezes all state
- iob_avalid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte strobes; all-zero means read
- iob_ready_o  out  1  request acceptance
- iob_rvalid_o  out  1  read data valid, one-cycle pulse
- iob_rdata_o  out  DATA_W  read data
- err_o  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Clock/reset: one clock clk_i; reset arst_i is asynchronous, active-high.
- Reset values: iob_ready_o=1, iob_rvalid_o=0, iob_rdata_o=0, err_o=0, FSM=IDLE, wait counter=0. Memory contents are not cleared.
- Acceptance: a request is accepted on a rising edge with cke_i=1, iob_avalid_i=1 and iob_ready_o=1.
  - addr, wdata and wstrb are captured into registers.
  - When iob_ready_o=0, the initiator holds the request stable and the responder ignores it.
- Word index: addr[MEM_ADDR_W+1:2]; addr[1:0] is ignored.
- Latency: for a request accepted at cycle T:
  - the memory access commits at the edge ending cycle T+WAIT_CYCLES;
  - a read's rdata and rvalid are visible in cycle T+1+WAIT_CYCLES;
  - iob_ready_o is 1 again in cycle T+1+WAIT_CYCLES, so the next request can be accepted while rvalid is shown.
- WAIT_CYCLES=0:
  - iob_ready_o stays 1 continuously; back-to-back requests are accepted every cycle.
  - Reads return data the next cycle.
- FSM states:
  - IDLE (ready=1). Accept with WAIT_CYCLES=0: perform the access, stay in IDLE. Accept with WAIT_CYCLES>0: load counter=WAIT_CYCLES, go to WAIT.
  - WAIT (ready=0). Decrement the counter each cycle. When counter==1, perform the access and go to IDLE.
- Writes (wstrb!=0):
  - Write only the bytes whose strobe is set; leave other bytes unchanged.
  - No rvalid pulse.
- Reads (wstrb==0):
  - iob_rvalid_o pulses for exactly one cycle.
  - iob_rdata_o holds its value until the next read response.
- Read-after-write: a read accepted immediately after a write to the same word returns the new data.
- cke_i=0: no acceptance, counter and FSM hold, outputs hold, no memory access.
- Reset mid-operation: an access that has not yet committed is dropped; a pending rvalid is cancelled; the block returns to the reset values.

Optional Feature:
- Macro: IOB_MEM_RESPONDER_RANGE_CHK_EN.
- Defined: an access is out of range when addr[ADDR_W-1:MEM_ADDR_W+2] != 0. For an out-of-range access:
  - a write is dropped;
  - a read returns 32'hDEADBEEF with the normal rvalid timing;
  - err_o is set and stays set until arst_i.
  - Timing and handshake are unchanged.
- Undefined: upper address bits are ignored (aliasing); err_o is tied to 0.

Decomposition:
- Shared package iob_mem_responder_pkg holds:
  - FSM state encoding (IDLE, WAIT);
  - the OOR read pattern 32'hDEADBEEF;
  - the WAIT_CYCLES counter width (4).
- One sub-module, iob_ram_sp_be: synchronous single-port RAM, per-byte write enable, 1-cycle read, no reset on the array.
- FSM, capture registers and range check stay in the top module.

Test Plan:
- WAIT_CYCLES=0: write 0x11223344 to 0x10 with wstrb=0xF, then read 0x10 -> ready stays 1, no rvalid on the write, rvalid one cycle after the read, rdata=0x11223344.
- Partial write: wstrb=0x2 with wdata=0x0000AA00 to 0x10, then read -> rdata=0x1122AA44.
- WAIT_CYCLES=3: read accepted at T -> ready=0 in T+1..T+3, ready=1 and rvalid=1 at T+4; a request held during the wait is not accepted twice.
- cke_i low for 2 cycles during WAIT -> rvalid delayed by exactly 2 cycles, data correct.
- arst_i pulsed in WAIT after a write is accepted -> ready=1, rvalid=0; a later read of that word returns the prior contents.
- With IOB_MEM_RESPONDER_RANGE_CHK_EN and MEM_ADDR_W=10: read 0x00001000 -> rdata=0xDEADBEEF and err_o=1; err_o stays 1 until reset; a write to 0x1000 leaves word 0 unchanged.
